// File: rtl/ncl_seq_pkg.sv
// rtl/ncl_seq_pkg.sv - dual-rail codes, sequencer states and bit encoder
package ncl_seq_pkg;

    localparam logic [1:0] DR_NULL    = 2'b00;
    localparam logic [1:0] DR_FALSE   = 2'b01;
    localparam logic [1:0] DR_TRUE    = 2'b10;
    localparam logic [1:0] DR_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DATA = 3'd1,
        ST_NULL = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    // Map a single-rail bit onto its dual-rail DATA code ([1]=TRUE rail).
    function automatic logic [1:0] dr_encode(input logic bit_val);
        return bit_val ? DR_TRUE : DR_FALSE;
    endfunction

endpackage

// File: rtl/ncl_dr_sync_detect.sv
// rtl/ncl_dr_sync_detect.sv - synchronizes dual-rail pairs and flags stable DATA/NULL/illegal codes
module ncl_dr_sync_detect #(
    parameter int NPAIRS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2*NPAIRS-1:0]   rails_in,
    output logic [NPAIRS-1:0]     true_rails,
    output logic                  data_complete,
    output logic                  null_complete,
    output logic                  illegal
);
    import ncl_seq_pkg::*;

    logic [2*NPAIRS-1:0] sync1;
    logic [2*NPAIRS-1:0] sync2;
    logic [2*NPAIRS-1:0] hist;
    logic                stable;
    logic                all_onehot;
    logic                any_illegal;
    logic [1:0]          pair;

    // Two-flop synchronizer followed by a one-deep history sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            hist  <= '0;
        end else begin
            sync1 <= rails_in;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    // A code only counts once it has been seen identically on two samples.
    assign stable = (sync2 == hist);

    // Classify every synchronized pair and pick out its TRUE rail.
    always_comb begin
        all_onehot  = 1'b1;
        any_illegal = 1'b0;
        pair        = DR_NULL;
        true_rails  = '0;
        for (int i = 0; i < NPAIRS; i++) begin
            pair          = sync2[2*i +: 2];
            true_rails[i] = pair[1];
            if (pair != DR_TRUE && pair != DR_FALSE) begin
                all_onehot = 1'b0;
            end
            if (pair == DR_ILLEGAL) begin
                any_illegal = 1'b1;
            end
        end
    end

    assign data_complete = stable && all_onehot;
    assign null_complete = stable && (sync2 == '0);
    assign illegal       = stable && any_illegal;

endmodule

// File: rtl/ncl_serial_add_seq.sv
// rtl/ncl_serial_add_seq.sv - bit-serial adder sequencing one dual-rail NCL full adder
module ncl_serial_add_seq #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             clear,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out,
    output logic             error,
    output logic [1:0]       fa_a,
    output logic [1:0]       fa_b,
    output logic [1:0]       fa_cin,
    input  logic [1:0]       fa_sum,
    input  logic [1:0]       fa_cout
);
    import ncl_seq_pkg::*;

    localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CNTW = $clog2(TIMEOUT);
    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(WIDTH - 1);
    localparam logic [CNTW-1:0] CNT_LIMIT = CNTW'(TIMEOUT - 1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDXW-1:0]  idx;
    logic [IDXW-1:0]  idx_next;
    logic             carry;
    logic [CNTW-1:0]  cnt;
    logic [1:0]       true_rails;
    logic             data_complete;
    logic             null_complete;
    logic             illegal;
    logic             timed_out;
    logic             last_bit;

    // Pair 1 carries the sum, pair 0 the carry-out.
    ncl_dr_sync_detect #(
        .NPAIRS(2)
    ) u_detect (
        .clk           (clk),
        .rst           (reset),
        .rails_in      ({fa_sum, fa_cout}),
        .true_rails    (true_rails),
        .data_complete (data_complete),
        .null_complete (null_complete),
        .illegal       (illegal)
    );

    assign idx_next  = idx + 1'b1;
    assign last_bit  = (idx == LAST_IDX);
    assign timed_out = (cnt == CNT_LIMIT);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: an illegal code outranks completion, completion outranks timeout.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (illegal)    next_state = ST_ERR;
                else if (start) next_state = ST_DATA;
            end
            ST_DATA: begin
                if (illegal)            next_state = ST_ERR;
                else if (data_complete) next_state = ST_NULL;
                else if (timed_out)     next_state = ST_ERR;
            end
            ST_NULL: begin
                if (illegal)            next_state = ST_ERR;
                else if (null_complete) next_state = last_bit ? ST_DONE : ST_DATA;
                else if (timed_out)     next_state = ST_ERR;
            end
            ST_DONE: begin
                if (illegal) next_state = ST_ERR;
                else         next_state = ST_IDLE;
            end
            ST_ERR: begin
                if (clear) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        busy  = (state == ST_DATA) || (state == ST_NULL) || (state == ST_DONE);
        done  = (state == ST_DONE);
        error = (state == ST_ERR);
    end

    // Datapath: operand latch, rail drive, bit capture, carry chain and phase timer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            sum_out  <= '0;
            cout_out <= 1'b0;
            fa_a     <= DR_NULL;
            fa_b     <= DR_NULL;
            fa_cin   <= DR_NULL;
        end else begin
            if (next_state != state) begin
                cnt <= '0;
            end else if (state == ST_DATA || state == ST_NULL) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end

            case (state)
                ST_IDLE: begin
                    if (next_state == ST_DATA) begin
                        a_q    <= a_in;
                        b_q    <= b_in;
                        idx    <= '0;
                        carry  <= cin_in;
                        fa_a   <= dr_encode(a_in[0]);
                        fa_b   <= dr_encode(b_in[0]);
                        fa_cin <= dr_encode(cin_in);
                    end
                end
                ST_DATA: begin
                    if (next_state == ST_NULL) begin
                        sum_out[idx] <= true_rails[1];
                        carry        <= true_rails[0];
                        fa_a         <= DR_NULL;
                        fa_b         <= DR_NULL;
                        fa_cin       <= DR_NULL;
                    end
                end
                ST_NULL: begin
                    if (next_state == ST_DONE) begin
                        cout_out <= carry;
                    end else if (next_state == ST_DATA) begin
                        idx    <= idx_next;
                        fa_a   <= dr_encode(a_q[idx_next]);
                        fa_b   <= dr_encode(b_q[idx_next]);
                        fa_cin <= dr_encode(carry);
                    end
                end
                default: ;
            endcase

            if (next_state == ST_ERR) begin
                fa_a   <= DR_NULL;
                fa_b   <= DR_NULL;
                fa_cin <= DR_NULL;
            end
        end
    end

endmodule

// File: tb/tb_ncl_serial_add_seq.sv
// tb/tb_ncl_serial_add_seq.sv - scoreboard bench for the serial NCL adder sequencer
module tb_ncl_serial_add_seq;

    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             clear;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum_out;
    logic             cout_out;
    logic             error;
    logic [1:0]       fa_a;
    logic [1:0]       fa_b;
    logic [1:0]       fa_cin;
    logic [1:0]       fa_sum  = 2'b00;
    logic [1:0]       fa_cout = 2'b00;

    ncl_serial_add_seq #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .clear    (clear),
        .a_in     (a_in),
        .b_in     (b_in),
        .cin_in   (cin_in),
        .busy     (busy),
        .done     (done),
        .sum_out  (sum_out),
        .cout_out (cout_out),
        .error    (error),
        .fa_a     (fa_a),
        .fa_b     (fa_b),
        .fa_cin   (fa_cin),
        .fa_sum   (fa_sum),
        .fa_cout  (fa_cout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        int               lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec     = 0;
    int   n_fail    = 0;
    int   n_push    = 0;
    int   done_cnt  = 0;
    int   start_cyc = 0;
    int   busy_low  = 0;
    int   min_run   = 0;
    int   err_at    = 0;

    // Adder model: 0 ideal, 1 random skew, 2 stuck NULL on bit 3, 3 sum=11 on bit 0
    int         model_mode  = 0;
    int         model_epoch = 0;
    int         seen_epoch  = 0;
    int         wave_cnt    = 0;
    int         skew_left   = 0;
    logic       prev_null   = 1'b1;
    logic [3:0] pend        = 4'b0000;

    always @(negedge clk) begin : adder_model
        logic       in_null;
        logic       s;
        logic       c;
        logic [3:0] tgt;
        if (model_epoch != seen_epoch) begin
            seen_epoch = model_epoch;
            wave_cnt   = 0;
        end
        in_null = (fa_a == 2'b00) && (fa_b == 2'b00) && (fa_cin == 2'b00);
        s   = fa_a[1] ^ fa_b[1] ^ fa_cin[1];
        c   = (fa_a[1] & fa_b[1]) | (fa_a[1] & fa_cin[1]) | (fa_b[1] & fa_cin[1]);
        tgt = in_null ? 4'b0000 : {s, ~s, c, ~c};
        if (!in_null && prev_null) wave_cnt++;
        prev_null = in_null;
        if (!in_null && model_mode == 2 && wave_cnt == 4) tgt = 4'b0000;
        if (!in_null && model_mode == 3 && wave_cnt == 1) tgt[3:2] = 2'b11;
        if (tgt != pend) begin
            pend      = tgt;
            skew_left = (model_mode == 1) ? int'($urandom_range(0, 5)) : 0;
        end
        if (skew_left == 0) {fa_sum, fa_cout} = pend;
        else skew_left--;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    check("sum_out", 64'(sum_out), 64'(e.sum));
                    check("cout_out", 64'(cout_out), 64'(e.cout));
                    if (e.lat >= 0) check("done_cycle", 64'(cyc), 64'(e.lat));
                end
            end
        end
    endtask

    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ci,
                         input logic push, input logic [WIDTH-1:0] es, input logic ec,
                         input logic chk_lat);
        exp_t e;
        a_in      = a;
        b_in      = b;
        cin_in    = ci;
        start     = 1'b1;
        start_cyc = cyc + 1;
        if (push) begin
            e.sum  = es;
            e.cout = ec;
            e.lat  = chk_lat ? start_cyc + 8 * WIDTH : -1;
            sb.push_back(e);
            n_push++;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int maxc);
        logic [1:0] prev;
        int         run;
        bit         seen;
        busy_low = 0;
        min_run  = 1000;
        prev     = fa_a;
        run      = 0;
        seen     = 1'b0;
        for (int i = 0; i < maxc && !seen; i++) begin
            if (fa_a == prev) run++;
            else begin
                if (run < min_run) min_run = run;
                run  = 1;
                prev = fa_a;
            end
            if (busy !== 1'b1) busy_low++;
            if (done === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        check({name, "_done_seen"}, 64'(seen), 64'd1);
        @(negedge clk);
    endtask

    task automatic wait_err(input int maxc);
        err_at = -1;
        for (int i = 0; i < maxc; i++) begin
            if (error === 1'b1) begin
                err_at = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        clear  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        cin_in = 1'b0;
        fork
            monitor();
        join_none
        repeat (2) @(negedge clk);
        check("reset_state", 64'({busy, done, error, cout_out, sum_out, fa_a, fa_b, fa_cin}), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // A5 + 3C, ideal adder: E1, four cycles per phase, busy throughout
        model_mode = 0;
        model_epoch++;
        issue(8'hA5, 8'h3C, 1'b0, 1'b1, 8'hE1, 1'b0, 1'b1);
        wait_done("ideal_a5", 100);
        check("ideal_busy_low_cycles", 64'(busy_low), 64'd0);
        check("ideal_phase_len", 64'(min_run), 64'd4);

        // FF + 01 + 1 ideal, then with skewed adder
        issue(8'hFF, 8'h01, 1'b1, 1'b1, 8'h01, 1'b1, 1'b1);
        wait_done("ideal_ff", 100);
        model_mode = 1;
        model_epoch++;
        issue(8'hFF, 8'h01, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0);
        wait_done("skew_ff", 400);
        check("skew_phase_min_ge4", 64'(min_run >= 4), 64'd1);

        // Adder stalls on bit 3 DATA: timeout
        model_mode = 2;
        model_epoch++;
        issue(8'h12, 8'h34, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        wait_err(200);
        check("stall_err_cycle", 64'(err_at), 64'(start_cyc + 24 + TIMEOUT));
        check("stall_rails_null", 64'({fa_a, fa_b, fa_cin}), 64'd0);
        check("stall_busy", 64'(busy), 64'd0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_idle", 64'({error, busy}), 64'd0);
        check("clear_sum_held", 64'({cout_out, sum_out}), 64'h106);
        model_mode = 0;
        model_epoch++;
        issue(8'h12, 8'h34, 1'b0, 1'b1, 8'h46, 1'b0, 1'b1);
        wait_done("after_clear", 100);

        // Illegal sum code on bit 0
        model_mode = 3;
        model_epoch++;
        issue(8'h0F, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        wait_err(20);
        check("illegal_err_in_time", 64'(err_at >= 0 && err_at <= start_cyc + 4), 64'd1);
        check("illegal_rails_null", 64'({fa_a, fa_b, fa_cin}), 64'd0);
        model_mode = 0;
        model_epoch++;
        repeat (6) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("illegal_cleared", 64'(error), 64'd0);

        // Reset in the middle of bit 5
        issue(8'h77, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 100 && cyc < start_cyc + 42; i++) @(negedge clk);
        reset = 1'b1;
        #1;
        check("async_reset_outputs", 64'({busy, done, error, cout_out, sum_out, fa_a, fa_b, fa_cin}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(8'h10, 8'h10, 1'b0, 1'b1, 8'h20, 1'b0, 1'b1);
        wait_done("after_reset", 100);

        // Second start while busy must be ignored
        issue(8'h5A, 8'h0F, 1'b0, 1'b1, 8'h69, 1'b0, 1'b1);
        repeat (9) @(negedge clk);
        a_in   = 8'hFF;
        b_in   = 8'hFF;
        cin_in = 1'b1;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        wait_done("busy_start", 100);

        repeat (100) @(negedge clk);
        check("done_count", 64'(done_cnt), 64'(n_push));
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/ncl_serial_add_seq.md
Name: ncl_serial_add_seq

Overview:
- Clocked sequencer that performs a WIDTH-bit binary addition by time-sharing a single dual-rail NCL full adder, one bit per DATA/NULL wavefront pair.
- Encodes operand bits onto dual-rail rails and waits for DATA completion, then NULL completion, on the adder's synchronized outputs.
- Captures each sum bit and feeds the carry back into the next bit.
- Sits between synchronous logic and an asynchronous full-adder cell. Also detects illegal rail codes and stalled wavefronts.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).
- TIMEOUT, 64, maximum cycles allowed in one DATA or NULL phase before error (>=8).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- clear  in  1  exits ERR; ignored in other states.
- a_in  in  WIDTH  operand A, latched on accepted start.
- b_in  in  WIDTH  operand B, latched on accepted start.
- cin_in  in  1  carry-in, latched on accepted start.
- busy  out  1  high in DATA/NULL/DONE.
- done  out  1  one-cycle pulse; result valid.
- sum_out  out  WIDTH  result, held until next accepted start.
- cout_out  out  1  final carry, held with sum_out.
- error  out  1  high while in ERR.
- fa_a, fa_b, fa_cin  out  2 each  dual-rail drive to the adder; [1]=TRUE rail, [0]=FALSE rail, 00=NULL.
- fa_sum, fa_cout  in  2 each  dual-rail adder outputs (asynchronous to clk).

Behaviour:
- Reset (async):
  - state=IDLE; all outputs 0.
  - fa_* rails are registered and forced 00 immediately.
  - Sync flops, bit index, carry and phase counter are cleared.
- States: IDLE, DATA, NULL, DONE, ERR.
- Returned rails (4 bits) pass through a 2-flop synchronizer, then a one-deep history register.
  - Phase condition is met only when the synchronized value satisfies the condition AND equals the history value (stable 2 samples).
- IDLE:
  - fa_*=00.
  - On start=1: latch operands, idx=0, carry=cin_in, state->DATA.
  - On that same edge: fa_a={a[0],~a[0]}, fa_b={b[0],~b[0]}, fa_cin={carry,~carry}.
- DATA:
  - Condition: both fa_sum and fa_cout one-hot, stable.
  - On condition: sum_out[idx]<=sum[1]; carry<=cout[1]; all fa_* <=00; ->NULL.
- NULL:
  - Condition: all four returned rails 0, stable.
  - If idx==WIDTH-1: cout_out<=carry; ->DONE.
  - Else: idx++; drive the next bit's encodings; ->DATA.
- DONE: done=1 for exactly one cycle; ->IDLE.
- Illegal code (11 on either pair, stable) in any state other than ERR: ->ERR, fa_*<=00.
- Phase counter:
  - Resets on entry to DATA or NULL.
  - Reaching TIMEOUT-1 without the condition: ->ERR.
- ERR:
  - error=1, fa_*=00, busy=0.
  - clear=1 -> IDLE; sum_out/cout_out unchanged.
- Latency with a zero-delay adder:
  - 4 cycles per phase, 8 per bit.
  - done asserts in the cycle after edge s+8*WIDTH, where s is the start edge.
- Simultaneous events:
  - start while busy or in ERR: ignored.
  - clear outside ERR: ignored.
  - Illegal code and timeout on the same edge: ERR (single destination).
- sum_out bits for indices not yet reached keep their previous values during operation. Consumers use done only.

Decomposition:
- Package ncl_seq_pkg holds:
  - dual-rail constants DR_NULL=2'b00, DR_FALSE=2'b01, DR_TRUE=2'b10, DR_ILLEGAL=2'b11;
  - state enum;
  - function encoding a bit onto dual rail.
- Sub-module ncl_dr_sync_detect: 2-flop sync, history register, and outputs data_complete, null_complete, illegal. Parameterized on number of dual-rail pairs (2 here).

Test Plan:
- A=8'hA5, B=8'h3C, cin=0, ideal adder model → sum_out=8'hE1, cout_out=0, done 64 cycles after start edge, busy high throughout.
- A=8'hFF, B=8'h01, cin=1 → sum_out=8'h01, cout_out=1. Adder model with random 0–5 cycle rail skew per phase → same result; each phase lasts ≥4 cycles.
- Adder model holds outputs NULL after bit 3 DATA drive → error=1 exactly TIMEOUT cycles after DATA entry, fa_* =00. clear → IDLE; a new start then completes correctly.
- Adder model returns fa_sum=2'b11 on bit 0 → ERR within 4 cycles, done never pulses.
- Assert reset for 1 cycle mid-way through bit 5 → fa_* =00 and outputs 0 asynchronously. A following start with 8'h10+8'h10, cin=0 → 8'h20, cout 0.
- Pulse start again 10 cycles into an operation with different operands → ignored; original result returned, single done pulse.
